// File: rtl/vip_frame_ctrl.sv
// vip_frame_ctrl: APB-programmed frame controller; commits mode/threshold atomically at frame boundaries, sequences runs, counts frames
// Build option: define VIP_FRAME_CTRL_IRQ_EN to enable CTRL.IRQ_EN and the irq output; otherwise irq=0 and CTRL[4] reads 0.
// Ports: clk/rst; APB3 slave psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr; vid_vsync frame sync;
//        cfg_mode/cfg_thresh committed settings; pipe_en frame gate; irq frame-done interrupt.
module vip_frame_ctrl #(
    parameter logic [7:0] THRESH_RST = 8'h40,
    parameter int         FCNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        vid_vsync,
    output logic [1:0]  cfg_mode,
    output logic [7:0]  cfg_thresh,
    output logic        pipe_en,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;
    state_t            r_state;
    logic              r_vs_prev, r_run, r_pend, r_done, r_irq_en, r_irq, r_pipe_en;
    logic [1:0]        r_mode_stg, r_cfg_mode;
    logic [7:0]        r_thresh_stg, r_cfg_thresh;
    logic [FCNT_W-1:0] r_fcnt;
    logic              w_wr, w_fb, w_done_set, w_start, w_unused;
    logic [1:0]        w_mode_commit;

    assign w_wr          = psel & penable & pwrite;
    assign w_fb          = vid_vsync & ~r_vs_prev;
    assign w_done_set    = (r_state == S_ACTIVE) & w_fb;
    assign w_start       = w_wr & (paddr[3:2] == 2'd0) & pwdata[1];
    // MODE 3 is reserved and falls back to bypass
    assign w_mode_commit = (r_mode_stg == 2'd3) ? 2'd0 : r_mode_stg;
    assign w_unused      = &{1'b0, pwdata, paddr[1:0]};

    assign pready     = 1'b1;
    assign pslverr    = 1'b0;
    assign cfg_mode   = r_cfg_mode;
    assign cfg_thresh = r_cfg_thresh;
    assign pipe_en    = r_pipe_en;
    assign irq        = r_irq;
    assign prdata     = (paddr[3:2] == 2'd0) ? {27'd0, r_irq_en, r_mode_stg, 1'b0, r_run} :
                        (paddr[3:2] == 2'd1) ? {24'd0, r_thresh_stg} :
                        (paddr[3:2] == 2'd2) ? {28'd0, r_cfg_mode, r_done, r_state != S_IDLE} :
                        32'(r_fcnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vs_prev    <= 1'b1;
            r_run        <= 1'b0;
            r_pend       <= 1'b0;
            r_done       <= 1'b0;
            r_pipe_en    <= 1'b0;
            r_mode_stg   <= 2'd0;
            r_cfg_mode   <= 2'd0;
            r_thresh_stg <= THRESH_RST;
            r_cfg_thresh <= THRESH_RST;
            r_fcnt       <= '0;
        end else begin
            r_vs_prev <= vid_vsync;
            if (w_wr && paddr[3:2] == 2'd0) begin
                r_run      <= pwdata[0];
                r_mode_stg <= pwdata[3:2];
            end
            if (w_wr && paddr[3:2] == 2'd1)
                r_thresh_stg <= pwdata[7:0];
            r_done <= w_done_set | (r_done & ~(w_wr & (paddr[3:2] == 2'd2) & pwdata[1]));
            if (w_wr && paddr[3:2] == 2'd3)
                r_fcnt <= '0;
            else if (w_done_set)
                r_fcnt <= r_fcnt + FCNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (r_run || w_start) begin
                        r_state <= S_ARMED;
                        r_pend  <= w_start;
                    end
                end
                S_ARMED: begin
                    if (w_fb) begin
                        r_state      <= S_ACTIVE;
                        r_pipe_en    <= 1'b1;
                        r_pend       <= 1'b0;
                        r_cfg_mode   <= w_mode_commit;
                        r_cfg_thresh <= r_thresh_stg;
                    end else if (!r_run && !r_pend)
                        r_state <= S_IDLE;
                end
                S_ACTIVE: begin
                    if (w_fb && r_run) begin
                        r_cfg_mode   <= w_mode_commit;
                        r_cfg_thresh <= r_thresh_stg;
                    end else if (w_fb) begin
                        r_state   <= S_IDLE;
                        r_pipe_en <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VIP_FRAME_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && paddr[3:2] == 2'd0)
                r_irq_en <= pwdata[4];
            r_irq <= r_done & r_irq_en;
        end
    end
`else
    assign r_irq_en = 1'b0;
    assign r_irq    = 1'b0;
`endif
endmodule

// File: doc/vip_frame_ctrl.md
# vip_frame_ctrl

Frame-synchronous controller for the video image-processing pipeline (RGB565 → Y → binary), sitting between the Cortex-M3 APB bus and the pipeline. Software programs mode and binarization threshold into staging registers. The block commits them atomically at frame boundaries so a frame is never processed with mixed settings. It sequences single-shot and continuous runs, gates the pipeline, counts processed frames and raises a frame-done interrupt.

## Interface
Parameters:
- THRESH_RST, 8'h40, reset value of the threshold staging and active registers.
- FCNT_W, 16, frame counter width (1..32).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- psel, penable, pwrite  in  1 each  APB3 control; access occurs when psel & penable.
- paddr  in  4  byte address; bits [1:0] ignored.
- pwdata  in  32  write data.
- prdata  out  32  read data, combinational from registers; 0 for unmapped addresses.
- pready  out  1  constant 1. pslverr: out, 1, constant 0.
- vid_vsync  in  1  frame sync from the pipeline input, active high.
- cfg_mode  out  2  committed mode: 0 bypass, 1 gray (Y), 2 binary.
- cfg_thresh  out  8  committed binarization threshold.
- pipe_en  out  1  high while a frame is being processed; gates pipeline de.
- irq  out  1  level interrupt.

## Operation
Registers:
- 0x0 CTRL: [0] RUN (continuous), [1] START (write-1 pulse, reads 0), [3:2] MODE staging, [4] IRQ_EN. Reset 0.
- 0x4 THRESH: [7:0] staging. Reset THRESH_RST.
- 0x8 STATUS: [0] BUSY (state != IDLE), [1] DONE (sticky, write-1-to-clear), [3:2] committed mode. Read-only otherwise.
- 0xC FCNT: [FCNT_W-1:0] completed frames; any write clears it; wraps from all-ones to 0.

Frame boundary (fb): vid_vsync high and its previous-cycle sample low. One register holds that sample, reset value 1, so no false fb follows reset.

FSM:
- IDLE: pipe_en=0. RUN=1 or START write → ARMED.
- ARMED: wait for fb. On fb: commit MODE→cfg_mode (MODE 3 commits as 0), THRESH→cfg_thresh → ACTIVE. If RUN clears with no pending START → IDLE.
- ACTIVE: pipe_en=1. On fb: FCNT+1, DONE set. If RUN=1: recommit, stay ACTIVE. Otherwise → IDLE.
- A START in single-shot mode yields exactly one ACTIVE frame.
- Clearing RUN mid-frame does not abort; the current frame completes.

Boundary rules:
- APB write to CTRL/THRESH in the same cycle as fb: the commit uses the pre-write value.
- FCNT clear write coincident with increment: clear wins, result 0.
- DONE W1C coincident with DONE set: set wins.
- START while BUSY: ignored.
- rst mid-frame: all state returns to reset on the next edge. pipe_en drops, IDLE, cfg_mode=0, cfg_thresh=THRESH_RST, FCNT=0, DONE=0.

## Timing
- Reset values: prdata 0 (reads of reset registers), pready 1, pslverr 0, cfg_mode 0, cfg_thresh THRESH_RST, pipe_en 0, irq 0.
- fb is detected in the first cycle vid_vsync is sampled high. State, cfg_* and FCNT update on that clock edge and are visible the next cycle (1-cycle latency).
- APB writes take effect the cycle after the access cycle. Reads have zero wait states.
- irq tracks DONE & IRQ_EN, registered; it asserts 1 cycle after DONE sets.

## Configuration
- VIP_FRAME_CTRL_IRQ_EN defined: DONE/IRQ_EN/irq logic as above.
- Not defined: irq is tied to 0, and CTRL[4] reads 0 and is not writable. DONE still sets and clears for polling.

## Test plan
- Reset, then read all registers → CTRL 0, THRESH 0x40, STATUS 0, FCNT 0; pipe_en 0, cfg_mode 0.
- Write THRESH=0x80, CTRL=0x2|MODE2, then pulse vsync → next cycle cfg_thresh 0x80, cfg_mode 2, pipe_en 1. Second vsync → pipe_en 0, FCNT 1, STATUS.DONE 1.
- RUN=1 over 3 vsync pulses, writing MODE=1 mid-frame 2 → mode changes only at the boundary after the write. FCNT 2 after the 3rd pulse, pipe_en stays 1.
- Write THRESH in the same cycle as the fb cycle → old value committed; new value appears at the following fb.
- With IRQ_EN=1, complete a frame → irq 1 one cycle after DONE. W1C DONE → irq 0. W1C coincident with a new fb → DONE remains 1.
- Preload FCNT to all-ones via frames, then one more frame → 0. Assert rst during ACTIVE → next cycle pipe_en 0, cfg_mode 0, BUSY 0.
